edge_event_scheduler: RTL

Multi-channel edge-event controller that owns NUM_CH edge-detect channels and serialises their events onto one valid/ready stream.
- Per channel: tracks the previous level, latches pending rising/falling events and flags lost events.
- Round-robin arbitration grants one event per cycle to a single consumer (interrupt/status logic).
- Sits between synchronised external lines (buttons, sensor strobes) and the control FSMs.

---
 rtl/edge_evt_pkg.sv | 20 ++
 rtl/edge_event_scheduler_if.sv | 16 +
 rtl/edge_evt_channel.sv | 116 +++++++++++
 rtl/edge_event_scheduler.sv | 110 +++++++++++
 4 files changed

// File: rtl/edge_evt_pkg.sv
// Shared types and constants for the edge event scheduler.
// Latency: none; declarations only.
// Backpressure: not applicable.
package edge_evt_pkg;

    localparam int MAX_CH     = 16;
    localparam int DEBOUNCE_W = 8;
    localparam int MAX_CH_W   = $clog2(MAX_CH);

    typedef enum logic {
        EDGE_FALL = 1'b0,
        EDGE_RISE = 1'b1
    } edge_kind_e;

    typedef struct packed {
        logic [MAX_CH_W-1:0] ch;
        logic                rising;
    } evt_t;

endpackage

// File: rtl/edge_event_scheduler_if.sv
// Event stream from the scheduler to its single consumer.
// Latency: none; wires only.
// Backpressure: valid/ready, producer holds the event while evt_ready is low.
interface edge_event_scheduler_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;
    logic            evt_rising;

    modport master (output evt_valid, output evt_ch, output evt_rising, input evt_ready);
    modport slave  (input evt_valid, input evt_ch, input evt_rising, output evt_ready);
endinterface

// File: rtl/edge_evt_channel.sv
// One edge channel: previous level, pending rise/fall flags, age bit, sticky overflow.
// Latency: a new edge is offered to the arbiter combinationally in the cycle it occurs.
// Backpressure: unserved edges stay pending; a repeat edge on a held flag raises overflow.
// Optional EDGE_DEBOUNCE_EN: a stability filter sits in front of edge detection.
module edge_evt_channel
    import edge_evt_pkg::*;
`ifdef EDGE_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYC = 8
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic       sig_i,
    input  logic       en_i,
    input  logic       rise_en_i,
    input  logic       fall_en_i,
    input  logic       take_i,
    input  logic       ovf_clear_i,
    output logic       req_o,
    output edge_kind_e kind_o,
    output logic       ovf_o
);

    logic level;

`ifdef EDGE_DEBOUNCE_EN
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
    logic                  filt_q, filt_d;

    // Filtered level follows sig_i only after DEBOUNCE_CYC consecutive mismatching cycles.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sig_i != filt_q) begin
            if (cnt_q == DEBOUNCE_W'(DEBOUNCE_CYC - 1)) filt_d = sig_i;
            else                                        cnt_d  = cnt_q + DEBOUNCE_W'(1);
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sig_i;
`endif

    logic prev_q, pr_q, pf_q, order_q, ovf_q;
    logic pr_d, pf_d, order_d, ovf_d;
    logic cap_r, cap_f, eff_r, eff_f, rise_older, rise_sel;
    logic take_r, take_f, kept_r, kept_f;

    assign cap_r = level & ~prev_q & en_i & rise_en_i;
    assign cap_f = ~level & prev_q & en_i & fall_en_i;

    // A fresh edge is offered in the same cycle so an idle output loads it at once.
    assign eff_r = pr_q | cap_r;
    assign eff_f = pf_q | cap_f;

    // order_q=1 means the fall flag is the older one; a fresh capture is always the younger.
    assign rise_older = pr_q & (~pf_q | ~order_q);
    assign rise_sel   = eff_r & (~eff_f | rise_older);

    assign req_o  = en_i & (eff_r | eff_f);
    assign kind_o = rise_sel ? EDGE_RISE : EDGE_FALL;
    assign ovf_o  = ovf_q;

    assign take_r = take_i & rise_sel;
    assign take_f = take_i & ~rise_sel;
    assign kept_r = pr_q & ~take_r;
    assign kept_f = pf_q & ~take_f;

    // Pending, age and overflow next state; a repeat edge on a flag being served re-arms it.
    always_comb begin
        ovf_d   = ovf_q & ~ovf_clear_i;
        order_d = order_q;
        pr_d    = take_r ? (cap_r & pr_q) : (pr_q | cap_r);
        pf_d    = take_f ? (cap_f & pf_q) : (pf_q | cap_f);
        if ((cap_r & kept_r) | (cap_f & kept_f)) ovf_d = 1'b1;
        if (kept_f & ~kept_r)       order_d = 1'b1;
        else if (kept_r & ~kept_f)  order_d = 1'b0;
        else if (~kept_r & ~kept_f) order_d = pf_d;
        if (!en_i) begin
            pr_d = 1'b0;
            pf_d = 1'b0;
        end
    end

    // Channel state registers; prev tracks the level whether or not the channel is enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q  <= 1'b0;
            pr_q    <= 1'b0;
            pf_q    <= 1'b0;
            order_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            prev_q  <= level;
            pr_q    <= pr_d;
            pf_q    <= pf_d;
            order_q <= order_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: rtl/edge_event_scheduler.sv
// Edge-event scheduler: NUM_CH edge channels, round-robin onto one valid/ready event stream.
// Latency: edge in cycle k is presented in cycle k+1 at the earliest (k+1+DEBOUNCE_CYC with filter).
// Backpressure: output held stable while evt_ready is low; edges queue as pending, repeats set overflow.
// Optional EDGE_DEBOUNCE_EN: enables per-channel debounce filters of DEBOUNCE_CYC cycles.
module edge_event_scheduler
    import edge_evt_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DEBOUNCE_CYC = 8
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     sig_in,
    input  logic [NUM_CH-1:0]     ch_enable,
    input  logic [NUM_CH-1:0]     rise_en,
    input  logic [NUM_CH-1:0]     fall_en,
    input  logic [NUM_CH-1:0]     ovf_clear,
    output logic [NUM_CH-1:0]     overflow,
    edge_event_scheduler_if.master evt_if
);

    localparam int CH_W = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > MAX_CH || DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > 255) begin : g_bad_param
        $error("edge_event_scheduler: parameter out of range");
    end

    logic [NUM_CH-1:0] req, grant;
    edge_kind_e        kind [NUM_CH];
    logic [CH_W-1:0]   rr_q, rr_d, ch_q, ch_d, win, cand;
    logic              vld_q, vld_d, rise_q, rise_d, found, load;
    int                idx;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        edge_evt_channel
`ifdef EDGE_DEBOUNCE_EN
            #(.DEBOUNCE_CYC(DEBOUNCE_CYC))
`endif
            u_ch (
                .clk         (clk),
                .reset       (reset),
                .sig_i       (sig_in[i]),
                .en_i        (ch_enable[i]),
                .rise_en_i   (rise_en[i]),
                .fall_en_i   (fall_en[i]),
                .take_i      (grant[i]),
                .ovf_clear_i (ovf_clear[i]),
                .req_o       (req[i]),
                .kind_o      (kind[i]),
                .ovf_o       (overflow[i])
            );
    end

    assign load = ~vld_q | evt_if.evt_ready;

    // First requesting channel at or above the RR pointer, wrapping past the top.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            cand = CH_W'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Output register load, grant back to the winning channel and pointer advance.
    always_comb begin
        vld_d  = vld_q;
        ch_d   = ch_q;
        rise_d = rise_q;
        rr_d   = rr_q;
        grant  = '0;
        if (load) begin
            vld_d = found;
            if (found) begin
                grant[win] = 1'b1;
                ch_d       = win;
                rise_d     = (kind[win] == EDGE_RISE);
                rr_d       = (win == CH_W'(NUM_CH - 1)) ? '0 : win + CH_W'(1);
            end
        end
    end

    // Output event and round-robin pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q  <= 1'b0;
            ch_q   <= '0;
            rise_q <= 1'b0;
            rr_q   <= '0;
        end else begin
            vld_q  <= vld_d;
            ch_q   <= ch_d;
            rise_q <= rise_d;
            rr_q   <= rr_d;
        end
    end

    assign evt_if.evt_valid  = vld_q;
    assign evt_if.evt_ch     = ch_q;
    assign evt_if.evt_rising = rise_q;

endmodule
